// File: rtl/kb_dmem_arbiter_if.sv
// Bus bundle between the CPU load/store path, the PS/2 receive path and the
// single-port data memory. The arbiter uses the slave view; the surrounding
// CPU/keyboard/memory side uses the master view.
interface kb_dmem_arbiter_if #(
  parameter int unsigned FIFO_DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;
  logic [7:0]    kb_data;
  logic          kb_valid;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata;
  logic [CW-1:0] kb_count;
  logic          kb_overflow;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, kb_data, kb_valid, mem_rdata,
    output cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_we, mem_re,
           kb_count, kb_overflow
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, kb_data, kb_valid, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_we, mem_re,
           kb_count, kb_overflow
  );
endinterface

// File: rtl/kb_dmem_arbiter.sv
// Data-memory port arbiter: CPU loads/stores share the single-port RAM with
// a keyboard byte FIFO that drains into a word ring buffer plus a write-pointer
// word that software polls.
module kb_dmem_arbiter #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] KB_BASE     = 32'h0000_0100,
  parameter int unsigned KB_LEN      = 16,
  parameter logic [31:0] KB_PTR_ADDR = 32'h0000_00FC
) (
  input logic           CLK,
  input logic           RST,
  kb_dmem_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = $clog2(KB_LEN);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CPU_RD   = 3'd1;
  localparam logic [2:0] CPU_DONE = 3'd2;
  localparam logic [2:0] KB_DATA  = 3'd3;
  localparam logic [2:0] KB_PTR   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          full, empty, pop, accept;
  logic          we_c, re_c, stall_c;
  logic [31:0]   addr_c, wdata_c;

  // Keyboard FIFO bookkeeping; a full FIFO still accepts when it pops this cycle.
  always_comb begin
    full       = (count_q == CW'(FIFO_DEPTH));
    empty      = (count_q == '0);
    pop        = (state_q == KB_DATA);
    accept     = bus.kb_valid && (!full || pop);
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.kb_valid && full && !pop);
    if (accept) begin
      fifo_d[wr_ptr_q] = bus.kb_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Arbitration FSM and memory-port drive; outputs are forced idle while RST is high.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    we_c    = 1'b0;
    re_c    = 1'b0;
    stall_c = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    case (state_q)
      IDLE: begin
        if (full) begin
          // Keyboard preempts; an unserviced CPU request must keep waiting.
          state_d = KB_DATA;
          stall_c = bus.cpu_req;
        end else if (bus.cpu_req && bus.cpu_we) begin
          we_c    = 1'b1;
          addr_c  = bus.cpu_addr;
          wdata_c = bus.cpu_wdata;
        end else if (bus.cpu_req) begin
          re_c    = 1'b1;
          addr_c  = bus.cpu_addr;
          stall_c = 1'b1;
          state_d = CPU_RD;
        end else if (!empty) begin
          state_d = KB_DATA;
        end
      end
      CPU_RD: begin
        stall_c = 1'b1;
        rdata_d = bus.mem_rdata;
        state_d = CPU_DONE;
      end
      CPU_DONE: begin
        state_d = IDLE;
      end
      KB_DATA: begin
        we_c    = 1'b1;
        addr_c  = KB_BASE + 32'({idx_q, 2'b00});
        wdata_c = {24'b0, fifo_q[rd_ptr_q]};
        idx_d   = idx_q + 1'b1;
        stall_c = bus.cpu_req;
        state_d = KB_PTR;
      end
      KB_PTR: begin
        we_c    = 1'b1;
        addr_c  = KB_PTR_ADDR;
        wdata_c = 32'(idx_q);
        stall_c = bus.cpu_req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (RST) begin
      we_c    = 1'b0;
      re_c    = 1'b0;
      stall_c = 1'b0;
      addr_c  = '0;
      wdata_c = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      fifo_q     <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.mem_we      = we_c;
  assign bus.mem_re      = re_c;
  assign bus.mem_addr    = addr_c;
  assign bus.mem_wdata   = wdata_c;
  assign bus.cpu_stall   = stall_c;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.kb_count    = count_q;
  assign bus.kb_overflow = overflow_q;
endmodule

// File: tb/tb_kb_dmem_arbiter.sv
// Directed bench for kb_dmem_arbiter with a behavioural single-port RAM.
module tb_kb_dmem_arbiter;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  kb_dmem_arbiter_if #(.FIFO_DEPTH(4)) bus ();

  kb_dmem_arbiter #(
    .FIFO_DEPTH (4),
    .KB_BASE    (32'h0000_0100),
    .KB_LEN     (16),
    .KB_PTR_ADDR(32'h0000_00FC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;

  logic [31:0] mem [0:255];
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_data [$];

  // Behavioural RAM: registered read, write on clock edge, plus a write log.
  always @(posedge CLK) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      wlog_addr.push_back(bus.mem_addr);
      wlog_data.push_back(bus.mem_wdata);
    end
  end

  task automatic drive_edge;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.kb_valid = 1'b0; bus.kb_data = '0;
    drive_edge();
    drive_edge();
    RST = 1'b0;
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge CLK);
      if (bus.kb_count == 0 && !bus.mem_we && !bus.mem_re && !bus.cpu_stall) begin
        ok = 1'b1;
        break;
      end
    end
    drive_edge();
  endtask

  task automatic test_reset;
    RST = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'hFFFF_FFFF;
    bus.kb_valid = 1'b0; bus.kb_data = '0;
    bus.mem_rdata = '0;
    @(negedge CLK);
    checks++;
    if ({bus.mem_we, bus.mem_re, bus.cpu_stall, bus.kb_overflow} !== 4'b0)
      $display("FAIL reset_ctrl: got %b expected 0000", {bus.mem_we, bus.mem_re, bus.cpu_stall, bus.kb_overflow});
    else passes++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'h0)
      $display("FAIL reset_bus: got %h/%h expected 0/0", bus.mem_addr, bus.mem_wdata);
    else passes++;
    checks++;
    if ({bus.cpu_rdata, bus.kb_count} !== 35'h0)
      $display("FAIL reset_rdata_count: got %h/%0d expected 0/0", bus.cpu_rdata, bus.kb_count);
    else passes++;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    drive_edge();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({bus.mem_we, bus.mem_re, bus.cpu_stall} !== 3'b0)
      $display("FAIL idle_after_reset: got %b expected 000", {bus.mem_we, bus.mem_re, bus.cpu_stall});
    else passes++;
    drive_edge();
  endtask

  task automatic test_kb_single;
    bus.kb_valid = 1'b1; bus.kb_data = 8'h1C;
    drive_edge();
    bus.kb_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.kb_count !== 3'd1 || bus.mem_we !== 1'b0)
      $display("FAIL kb1_queued: got count %0d we %b expected 1 0", bus.kb_count, bus.mem_we);
    else passes++;
    @(negedge CLK);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'h1C)
      $display("FAIL kb1_data: got we %b %h=%h expected 1 00000100=0000001c", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else passes++;
    @(negedge CLK);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'hFC || bus.mem_wdata !== 32'h1 || bus.kb_count !== 3'd0)
      $display("FAIL kb1_ptr: got we %b %h=%h count %0d expected 1 000000fc=00000001 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.kb_count);
    else passes++;
    @(negedge CLK);
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0)
      $display("FAIL kb1_done: got we %b addr %h expected 0 0", bus.mem_we, bus.mem_addr);
    else passes++;
    drive_edge();
  endtask

  task automatic test_store;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 32'h40 ||
        bus.mem_wdata !== 32'hDEADBEEF || bus.cpu_stall !== 1'b0)
      $display("FAIL store: got we %b re %b %h=%h stall %b expected 1 0 00000040=deadbeef 0",
               bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.cpu_stall);
    else passes++;
    drive_edge();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    @(negedge CLK);
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0)
      $display("FAIL store_single_cycle: got we %b %h=%h expected 0 0=0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else passes++;
    drive_edge();
  endtask

  task automatic test_load;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'h12345678;
    drive_edge();
    bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
    @(negedge CLK);
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h80 || bus.cpu_stall !== 1'b1)
      $display("FAIL load_issue: got re %b we %b addr %h stall %b expected 1 0 00000080 1",
               bus.mem_re, bus.mem_we, bus.mem_addr, bus.cpu_stall);
    else passes++;
    @(negedge CLK);
    checks++;
    if (bus.cpu_stall !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 32'h0)
      $display("FAIL load_wait: got stall %b re %b addr %h expected 1 0 0", bus.cpu_stall, bus.mem_re, bus.mem_addr);
    else passes++;
    @(negedge CLK);
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'h12345678)
      $display("FAIL load_done: got stall %b rdata %h expected 0 12345678", bus.cpu_stall, bus.cpu_rdata);
    else passes++;
    drive_edge();
    bus.cpu_req = 1'b0; bus.cpu_addr = '0;
  endtask

  task automatic test_preempt;
    bit seen_pre, stall_bad, drop, done;
    logic [31:0] ra [$];
    logic [31:0] rd [$];
    logic [31:0] last_ptr;
    do_reset();
    seen_pre = 0; stall_bad = 0; drop = 0; done = 0; last_ptr = '1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      bus.kb_valid = 1'b1; bus.kb_data = 8'hA1 + 8'(i);
      drive_edge();
    end
    bus.kb_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (bus.cpu_req && bus.mem_we && (bus.mem_addr == 32'hFC ||
          (bus.mem_addr >= 32'h100 && bus.mem_addr < 32'h140))) begin
        seen_pre = 1'b1;
        if (bus.cpu_stall !== 1'b1) stall_bad = 1'b1;
      end
      if (bus.cpu_req && seen_pre && !bus.cpu_stall) drop = 1'b1;
      if (!bus.cpu_req && bus.kb_count == 0 && !bus.mem_we && !bus.mem_re) begin
        done = 1'b1;
        break;
      end
      drive_edge();
      if (drop) bus.cpu_req = 1'b0;
    end
    drive_edge();
    bus.cpu_req = 1'b0;
    checks++;
    if (!done) $display("FAIL preempt_timeout: got not drained expected drained within 40 cycles");
    else passes++;
    checks++;
    if (!seen_pre || stall_bad)
      $display("FAIL preempt_stall: got seen %b stall_bad %b expected 1 0", seen_pre, stall_bad);
    else passes++;
    for (int i = 0; i < wlog_addr.size(); i++) begin
      if (wlog_addr[i] == 32'hFC) last_ptr = wlog_data[i];
      else begin ra.push_back(wlog_addr[i]); rd.push_back(wlog_data[i]); end
    end
    checks++;
    if (ra.size() != 4) $display("FAIL preempt_ring_count: got %0d expected 4", ra.size());
    else passes++;
    for (int i = 0; i < 4 && i < ra.size(); i++) begin
      checks++;
      if (ra[i] !== 32'h100 + 32'(4 * i) || rd[i] !== 32'hA1 + 32'(i))
        $display("FAIL preempt_ring_%0d: got %h=%h expected %h=%h", i, ra[i], rd[i],
                 32'h100 + 32'(4 * i), 32'hA1 + 32'(i));
      else passes++;
    end
    checks++;
    if (last_ptr !== 32'd4 || bus.cpu_rdata !== 32'hDEADBEEF)
      $display("FAIL preempt_ptr_rdata: got %h/%h expected 00000004/deadbeef", last_ptr, bus.cpu_rdata);
    else passes++;
  endtask

  task automatic test_wrap_overflow;
    bit ok, drop;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.kb_valid = 1'b1; bus.kb_data = 8'h30 + 8'(i);
      drive_edge();
      bus.kb_valid = 1'b0;
      repeat (4) drive_edge();
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) $display("FAIL wrap_timeout: got not drained expected drained");
    else passes++;
    checks++;
    if (mem[64] !== 32'h40 || mem[63] !== 32'h1 || mem[79] !== 32'h3F || mem[65] !== 32'h31)
      $display("FAIL wrap_ring: got [100]=%h ptr=%h [13c]=%h [104]=%h expected 40 1 3f 31",
               mem[64], mem[63], mem[79], mem[65]);
    else passes++;
    checks++;
    if (wlog_addr.size() != 34 || bus.kb_overflow !== 1'b0)
      $display("FAIL wrap_writes: got %0d writes ovf %b expected 34 0", wlog_addr.size(), bus.kb_overflow);
    else passes++;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
    for (int i = 0; i < 6; i++) begin
      bus.kb_valid = 1'b1; bus.kb_data = 8'h60 + 8'(i);
      drive_edge();
    end
    bus.kb_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.kb_overflow !== 1'b1 || bus.kb_count !== 3'd4)
      $display("FAIL overflow_flag: got ovf %b count %0d expected 1 4", bus.kb_overflow, bus.kb_count);
    else passes++;
    drop = 1'b0;
    for (int c = 0; c < 20 && !drop; c++) begin
      if (!bus.cpu_stall) drop = 1'b1;
      drive_edge();
      if (!drop) @(negedge CLK);
    end
    bus.cpu_req = 1'b0;
    wait_drain(20, ok);
    checks++;
    if (!ok || !drop) $display("FAIL overflow_drain: got drained %b released %b expected 1 1", ok, drop);
    else passes++;
    checks++;
    if (mem[65] !== 32'h60 || mem[68] !== 32'h63 || mem[69] !== 32'h35 || mem[63] !== 32'h5)
      $display("FAIL overflow_ring: got %h %h %h ptr %h expected 60 63 35 5", mem[65], mem[68], mem[69], mem[63]);
    else passes++;
    checks++;
    if (bus.kb_overflow !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", bus.kb_overflow);
    else passes++;
  endtask

  task automatic test_reset_mid;
    bit found, ok;
    int n77;
    do_reset();
    @(negedge CLK);
    checks++;
    if (bus.kb_overflow !== 1'b0) $display("FAIL overflow_cleared: got %b expected 0", bus.kb_overflow);
    else passes++;
    drive_edge();
    bus.kb_valid = 1'b1; bus.kb_data = 8'h77;
    drive_edge();
    bus.kb_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.mem_we && bus.mem_addr == 32'h100) begin
        found = 1'b1;
        break;
      end
    end
    RST = 1'b1;
    #1;
    checks++;
    if (!found || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.kb_count !== 3'd0)
      $display("FAIL reset_mid: got found %b we %b addr %h count %0d expected 1 0 0 0",
               found, bus.mem_we, bus.mem_addr, bus.kb_count);
    else passes++;
    drive_edge();
    RST = 1'b0;
    bus.kb_valid = 1'b1; bus.kb_data = 8'h55;
    drive_edge();
    bus.kb_valid = 1'b0;
    wait_drain(20, ok);
    n77 = 0;
    for (int i = 0; i < wlog_data.size(); i++) if (wlog_data[i] == 32'h77) n77++;
    checks++;
    if (!ok || n77 != 0 || mem[64] !== 32'h55 || mem[63] !== 32'h1)
      $display("FAIL reset_mid_after: got drained %b aborted_writes %0d [100]=%h ptr=%h expected 1 0 55 1",
               ok, n77, mem[64], mem[63]);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_kb_single();
    test_store();
    test_load();
    test_preempt();
    test_wrap_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
